// File: rtl/tia_hcounter_gen.sv
// Horizontal colour-clock counter and timing generator.
// A binary line counter replaces the legacy horizontal LFSR chain. The block
// derives sync, colour burst and blank windows from the count, handles HMOVE
// extended blank with a bounded motion-clock burst, and halts the CPU on WSYNC
// until the next line start. Every output is registered and reflects the
// post-update state, so all of them change on the same edge as hcnt.
module tia_hcounter_gen #(
  parameter int CW           = 8,
  parameter int LINE_CLKS    = 228,
  parameter int HSYNC_START  = 16,
  parameter int HSYNC_END    = 32,
  parameter int CB_START     = 36,
  parameter int CB_END       = 52,
  parameter int HBLANK_END   = 68,
  parameter int HMOVE_EXT    = 8,
  parameter int MOTCK_PULSES = 15,
  parameter int MOTCK_DIV    = 4,
  parameter int RSYNC_LOAD   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rsyn,
  input  logic          wsyn,
  input  logic          hmove,
  input  logic          vsyn,
  input  logic          vblk,
  output logic [CW-1:0] hcnt,
  output logic          line_start,
  output logic          syn,
  output logic          cb,
  output logic          blank,
  output logic          sec,
  output logic          motck,
  output logic          rdy
);

  localparam int MW = (MOTCK_PULSES < 1) ? 1 : $clog2(MOTCK_PULSES + 1);
  localparam int DW = $clog2(MOTCK_DIV);

  localparam logic [CW-1:0] LAST_C   = CW'(LINE_CLKS - 1);
  localparam logic [CW-1:0] LOAD_C   = CW'(RSYNC_LOAD);
  localparam logic [CW-1:0] HS_LO_C  = CW'(HSYNC_START);
  localparam logic [CW-1:0] HS_HI_C  = CW'(HSYNC_END);
  localparam logic [CW-1:0] CB_LO_C  = CW'(CB_START);
  localparam logic [CW-1:0] CB_HI_C  = CW'(CB_END);
  localparam logic [CW-1:0] HB_C     = CW'(HBLANK_END);
  localparam logic [CW-1:0] HBX_C    = CW'(HBLANK_END + HMOVE_EXT);
  localparam logic [MW-1:0] MCNT_LD  = MW'(MOTCK_PULSES);
  localparam logic [DW-1:0] DIV_LD   = DW'(MOTCK_DIV - 1);

  // Half-open window test lo <= v < hi.
  function automatic logic in_win(input logic [CW-1:0] v,
                                  input logic [CW-1:0] lo,
                                  input logic [CW-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          ls_q, ls_d;
  logic          syn_q, syn_d;
  logic          cb_q, cb_d;
  logic          blank_q, blank_d;
  logic          sec_q, sec_d;
  logic          pend_q, pend_d;
  logic          motck_q, motck_d;
  logic          rdy_q, rdy_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          hm_now;
  logic          load_m;

  // Next-state: counter first, then everything derived from the updated count.
  always_comb begin
    hcnt_d  = hcnt_q;
    ls_d    = 1'b0;
    sec_d   = sec_q;
    pend_d  = pend_q;
    rdy_d   = rdy_q;
    mcnt_d  = mcnt_q;
    div_d   = div_q;
    motck_d = 1'b0;
    hm_now  = 1'b0;
    load_m  = 1'b0;

    if (rsyn)                  hcnt_d = LOAD_C;
    else if (hcnt_q == LAST_C) hcnt_d = '0;
    else                       hcnt_d = hcnt_q + 1'b1;
    ls_d = (hcnt_d == '0);

    // The HMOVE window is judged on the post-update count, so an rsyn load in
    // the same cycle moves the strobe into the new line's blank region.
    hm_now = hmove && (hcnt_d < HB_C);
    if (ls_d) begin
      sec_d  = pend_q | hm_now;
      pend_d = 1'b0;
      load_m = pend_q | hm_now;
    end else begin
      sec_d  = sec_q | hm_now;
      pend_d = pend_q | (hmove & ~hm_now);
      load_m = hm_now;
    end

    // Motion burst: div counts clocks to the next pulse, mcnt pulses left.
    if (load_m) begin
      mcnt_d = MCNT_LD;
      div_d  = DIV_LD;
    end else if (mcnt_q != '0) begin
      if (div_q == '0) begin
        motck_d = 1'b1;
        mcnt_d  = mcnt_q - 1'b1;
        div_d   = DIV_LD;
      end else begin
        div_d = div_q - 1'b1;
      end
    end

    // A wsyn arriving with the line start re-halts for a whole further line.
    if (ls_d)      rdy_d = ~wsyn;
    else if (wsyn) rdy_d = 1'b0;

    syn_d   = in_win(hcnt_d, HS_LO_C, HS_HI_C) ^ vsyn;
    cb_d    = in_win(hcnt_d, CB_LO_C, CB_HI_C) & ~vsyn;
    blank_d = vblk | (hcnt_d < (sec_d ? HBX_C : HB_C));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q  <= '0;
      ls_q    <= 1'b0;
      syn_q   <= 1'b0;
      cb_q    <= 1'b0;
      blank_q <= 1'b1;
      sec_q   <= 1'b0;
      pend_q  <= 1'b0;
      motck_q <= 1'b0;
      rdy_q   <= 1'b1;
      mcnt_q  <= '0;
      div_q   <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      ls_q    <= ls_d;
      syn_q   <= syn_d;
      cb_q    <= cb_d;
      blank_q <= blank_d;
      sec_q   <= sec_d;
      pend_q  <= pend_d;
      motck_q <= motck_d;
      rdy_q   <= rdy_d;
      mcnt_q  <= mcnt_d;
      div_q   <= div_d;
    end
  end

  assign hcnt       = hcnt_q;
  assign line_start = ls_q;
  assign syn        = syn_q;
  assign cb         = cb_q;
  assign blank      = blank_q;
  assign sec        = sec_q;
  assign motck      = motck_q;
  assign rdy        = rdy_q;

endmodule

// File: doc/tia_hcounter_gen.md
Name: tia_hcounter_gen

Overview:
- Parametrised, single-clock successor to the biphase-clock / horizontal-LFSR / decoder / horizontal-timing chain.
- Replaces the fixed 57-state LFSR with a binary colour-clock counter. Line length, blank, sync and colour-burst windows are configurable.
- Adds HMOVE extended blank with a bounded motion-clock burst, and a WSYNC/RDY handshake.
- Drives the playfield/object pipeline and the composite video encoder in place of the legacy horizontal timing chain.

Parameters:
- CW, 8: counter width in bits; must satisfy 2^CW >= LINE_CLKS.
- LINE_CLKS, 228: colour clocks per line; counter runs 0..LINE_CLKS-1.
- HSYNC_START, 16: first count with horizontal sync active.
- HSYNC_END, 32: first count with horizontal sync inactive.
- CB_START, 36: first count of the colour-burst window.
- CB_END, 52: first count after the colour-burst window.
- HBLANK_END, 68: first visible count when no HMOVE is active.
- HMOVE_EXT, 8: extra blank clocks added to the line when HMOVE is active.
- MOTCK_PULSES, 15: number of motion-clock pulses per HMOVE.
- MOTCK_DIV, 4: colour clocks between motion-clock pulses; must be >= 2.
- RSYNC_LOAD, 0: counter value loaded on rsyn.

Ports:
- clk, input, 1: colour clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- rsyn, input, 1: one-cycle strobe; resynchronise the line counter.
- wsyn, input, 1: one-cycle strobe; halt the CPU until the next line start.
- hmove, input, 1: one-cycle strobe; apply horizontal motion.
- vsyn, input, 1: vertical sync level from the vertical register.
- vblk, input, 1: vertical blank level from the vertical register.
- hcnt, output, CW: current colour-clock count.
- line_start, output, 1: one-cycle pulse whenever hcnt becomes 0.
- syn, output, 1: composite sync.
- cb, output, 1: colour-burst gate.
- blank, output, 1: composite blank.
- sec, output, 1: HMOVE extended blank is active on this line.
- motck, output, 1: motion-clock pulse.
- rdy, output, 1: CPU ready; 0 halts the CPU.

Behaviour:
- All outputs are registered. Every output value is a function of the post-update state, i.e. it updates in the same edge as hcnt.
- Reset (rst=1 at an edge), which overrides every other input:
  - hcnt=0, line_start=0, syn=0, cb=0, blank=1, sec=0, motck=0, rdy=1.
  - HMOVE pending flag and motion-pulse counter are cleared.
- Counter:
  - If rsyn=1, hcnt loads RSYNC_LOAD.
  - Otherwise, at LINE_CLKS-1 it wraps to 0.
  - Otherwise it increments.
  - line_start=1 exactly in the cycle in which hcnt is 0 after an update, whether reached by wrap or by the rsyn load. It is not asserted on reset.
- Windows, where hs means HSYNC_START <= hcnt < HSYNC_END:
  - syn = hs XOR vsyn.
  - cb = 1 when CB_START <= hcnt < CB_END and vsyn=0.
  - blank = vblk OR (hcnt < blank_end). blank_end is HBLANK_END, or HBLANK_END+HMOVE_EXT when sec=1.
- HMOVE handling:
  - An hmove strobe while hcnt < HBLANK_END sets sec for the current line. Otherwise it sets a pending flag.
  - When line_start occurs, sec takes the value of the pending flag and the pending flag clears.
  - sec also clears at line_start when no hmove is pending.
  - Whenever sec is set (immediately or via pending), the motion-pulse counter loads MOTCK_PULSES.
  - motck pulses high for one clock every MOTCK_DIV clocks. The first pulse is MOTCK_DIV clocks after sec rises. The counter decrements on each pulse and stops at 0.
  - A new hmove while pulses remain reloads the counter and restarts the divider phase.
- WSYNC handling:
  - A wsyn strobe sets rdy=0 on the next edge.
  - rdy returns to 1 in the cycle where line_start=1.
  - A wsyn strobe in the same cycle that produces line_start leaves rdy=0 until the following line_start.
  - Repeated wsyn while rdy=0 has no effect.
- Simultaneous events:
  - rsyn and hmove in the same cycle: the hmove window test uses the post-load hcnt.
  - rsyn and wsyn in the same cycle: the load produces line_start only if RSYNC_LOAD=0. In that case wsyn still takes effect, per the same-cycle WSYNC rule above.
- vsyn and vblk are combinational inputs into the registered outputs. They are sampled every cycle and are not latched per line.

Test Plan:
- Reset then free-run 460 clocks:
  - line_start at hcnt=0, period 228.
  - syn high for counts 16..31; cb high for 36..51; blank high for 0..67, low from 68.
- vsyn=1 for one line: syn is low for 16..31 and high elsewhere; cb stays 0 for the whole line.
- hmove at hcnt=10:
  - sec=1 from the next edge; blank extends through count 75.
  - 15 motck pulses, 4 clocks apart, the first 4 clocks after sec rises.
  - sec clears at the next line_start.
- hmove at hcnt=100: sec stays 0 this line, becomes 1 at the next line_start, and blank ends at 76 on that line.
- wsyn at hcnt=50: rdy=0 from hcnt=51 through 227; rdy=1 coincident with line_start. A second wsyn at hcnt=120 causes no change.
- rsyn at hcnt=150 with RSYNC_LOAD=0:
  - hcnt=0 and line_start pulse on the next edge; pending wsyn releases.
  - Assert rst mid-line during a motck burst: all outputs return to reset values on that edge; no further motck pulses.
